// File: rtl/exec_ctrl_pkg.sv
// Shared types and constants for the multi-cycle execution controller.
package exec_ctrl_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] ALU_R   = 3'b000;
    localparam logic [2:0] ALU_I   = 3'b001;
    localparam logic [2:0] ALU_LD  = 3'b010;
    localparam logic [2:0] ALU_ST  = 3'b011;
    localparam logic [2:0] ALU_BR  = 3'b100;
    localparam logic [2:0] ALU_JAL = 3'b101;
    localparam logic [2:0] ALU_LUI = 3'b110;

    typedef struct packed {
        logic [2:0] aluop;
        logic       alu_src;
        logic       branch;
        logic       mux_inp;
        logic       is_load;
        logic       is_store;
        logic       is_jump;
        logic       legal;
    } ctrl_t;

endpackage

// File: rtl/exec_ctrl_if.sv
// Controller-side bundle: instruction/memory handshakes in, EX controls and sequencing out.
interface exec_ctrl_if;
    import exec_ctrl_pkg::*;

    logic [XLEN-1:0] instr;
    logic            instr_valid;
    logic            mem_ready;
    logic            and_out_ex;

    logic [2:0]      aluop;
    logic            alu_src;
    logic            branch;
    logic            mux_inp;
    logic [2:0]      fn3;
    logic            fn7_5;
    logic [6:0]      imm11_5;

    logic            instr_req;
    logic            ir_we;
    logic            mem_rd;
    logic            mem_wr;
    logic            reg_we;
    logic            pc_we;
    logic            pc_src;
    logic            trap;
    logic            halted;
    logic [XLEN-1:0] instret;

    modport master (
        input  instr, instr_valid, mem_ready, and_out_ex,
        output aluop, alu_src, branch, mux_inp, fn3, fn7_5, imm11_5,
        output instr_req, ir_we, mem_rd, mem_wr, reg_we, pc_we, pc_src,
        output trap, halted, instret
    );

    modport slave (
        output instr, instr_valid, mem_ready, and_out_ex,
        input  aluop, alu_src, branch, mux_inp, fn3, fn7_5, imm11_5,
        input  instr_req, ir_we, mem_rd, mem_wr, reg_we, pc_we, pc_src,
        input  trap, halted, instret
    );

endinterface

// File: rtl/exec_ctrl_decode.sv
// Opcode to execution-control mapping; purely combinational.
module exec_ctrl_decode
    import exec_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output ctrl_t      o_ctrl_c
);

    always_comb begin
        o_ctrl_c       = '0;
        o_ctrl_c.legal = 1'b1;
        case (i_opcode)
            OP_R:      o_ctrl_c.aluop = ALU_R;
            OP_I: begin
                o_ctrl_c.aluop   = ALU_I;
                o_ctrl_c.alu_src = 1'b1;
            end
            OP_LOAD: begin
                o_ctrl_c.aluop   = ALU_LD;
                o_ctrl_c.alu_src = 1'b1;
                o_ctrl_c.is_load = 1'b1;
            end
            OP_STORE: begin
                o_ctrl_c.aluop    = ALU_ST;
                o_ctrl_c.alu_src  = 1'b1;
                o_ctrl_c.is_store = 1'b1;
            end
            OP_BRANCH: begin
                o_ctrl_c.aluop  = ALU_BR;
                o_ctrl_c.branch = 1'b1;
            end
            OP_JAL: begin
                o_ctrl_c.aluop   = ALU_JAL;
                o_ctrl_c.alu_src = 1'b1;
                o_ctrl_c.is_jump = 1'b1;
            end
            OP_JALR: begin
                o_ctrl_c.aluop   = ALU_I;
                o_ctrl_c.alu_src = 1'b1;
                o_ctrl_c.mux_inp = 1'b1;
                o_ctrl_c.is_jump = 1'b1;
            end
            OP_LUI: begin
                o_ctrl_c.aluop   = ALU_LUI;
                o_ctrl_c.alu_src = 1'b1;
            end
            OP_AUIPC: begin
                o_ctrl_c.aluop   = ALU_I;
                o_ctrl_c.alu_src = 1'b1;
            end
            default:   o_ctrl_c.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory timeout and retire counter.
// Every output is a register updated on the transition into the cycle it describes.
module exec_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    exec_ctrl_if.master bus
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_mem_cnt;
    logic [XLEN-1:0]   r_instret;
    logic [2:0]        r_aluop;
    logic              r_alu_src, r_branch, r_mux_inp;
    logic              r_is_load, r_is_store, r_is_jump;
    logic [2:0]        r_fn3;
    logic              r_fn7_5;
    logic [6:0]        r_imm11_5;
    logic              r_instr_req, r_ir_we, r_mem_rd, r_mem_wr;
    logic              r_reg_we, r_pc_we, r_pc_src, r_trap, r_halted;
    ctrl_t             w_dec;
    logic              w_unused_instr;

    exec_ctrl_decode u_decode (
        .i_opcode (bus.instr[6:0]),
        .o_ctrl_c (w_dec)
    );

    assign w_unused_instr = ^{bus.instr[24:15], bus.instr[11:7]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_FETCH;
            r_mem_cnt   <= '0;
            r_instret   <= '0;
            r_aluop     <= '0;
            r_alu_src   <= 1'b0;
            r_branch    <= 1'b0;
            r_mux_inp   <= 1'b0;
            r_is_load   <= 1'b0;
            r_is_store  <= 1'b0;
            r_is_jump   <= 1'b0;
            r_fn3       <= '0;
            r_fn7_5     <= 1'b0;
            r_imm11_5   <= '0;
            r_instr_req <= 1'b1;
            r_ir_we     <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_reg_we    <= 1'b0;
            r_pc_we     <= 1'b0;
            r_pc_src    <= 1'b0;
            r_trap      <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_ir_we  <= 1'b0;
            r_reg_we <= 1'b0;
            r_pc_we  <= 1'b0;
            r_pc_src <= 1'b0;
            r_trap   <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (bus.instr_valid) begin
                        r_state     <= S_DECODE;
                        r_instr_req <= 1'b0;
                        r_ir_we     <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (!w_dec.legal) begin
                        r_state    <= S_HALT;
                        r_trap     <= 1'b1;
                        r_halted   <= 1'b1;
                        r_aluop    <= '0;
                        r_alu_src  <= 1'b0;
                        r_branch   <= 1'b0;
                        r_mux_inp  <= 1'b0;
                        r_fn3      <= '0;
                        r_fn7_5    <= 1'b0;
                        r_imm11_5  <= '0;
                    end else begin
                        r_state    <= S_EXEC;
                        r_aluop    <= w_dec.aluop;
                        r_alu_src  <= w_dec.alu_src;
                        r_branch   <= w_dec.branch;
                        r_mux_inp  <= w_dec.mux_inp;
                        r_is_load  <= w_dec.is_load;
                        r_is_store <= w_dec.is_store;
                        r_is_jump  <= w_dec.is_jump;
                        r_fn3      <= bus.instr[14:12];
                        r_fn7_5    <= bus.instr[30];
                        r_imm11_5  <= bus.instr[31:25];
                        // Branch redirect is presented during EXEC; flag sampled as EXEC is entered.
                        if (w_dec.branch) begin
                            r_pc_we  <= 1'b1;
                            r_pc_src <= bus.and_out_ex;
                        end
                    end
                end
                S_EXEC: begin
                    if (r_branch) begin
                        r_state     <= S_FETCH;
                        r_instr_req <= 1'b1;
                        r_instret   <= r_instret + XLEN'(1);
                    end else if (r_is_load || r_is_store) begin
                        r_state   <= S_MEM;
                        r_mem_cnt <= '0;
                        r_mem_rd  <= r_is_load;
                        r_mem_wr  <= r_is_store;
                    end else begin
                        r_state  <= S_WB;
                        r_reg_we <= 1'b1;
                        r_pc_we  <= 1'b1;
                        r_pc_src <= r_is_jump;
                    end
                end
                S_MEM: begin
                    // mem_ready takes priority over an expiring timeout in the same cycle.
                    if (bus.mem_ready) begin
                        r_mem_rd <= 1'b0;
                        r_mem_wr <= 1'b0;
                        if (r_is_store) begin
                            r_state     <= S_FETCH;
                            r_instr_req <= 1'b1;
                            r_pc_we     <= 1'b1;
                            r_instret   <= r_instret + XLEN'(1);
                        end else begin
                            r_state  <= S_WB;
                            r_reg_we <= 1'b1;
                            r_pc_we  <= 1'b1;
                        end
                    end else if (r_mem_cnt == TMO_LAST) begin
                        r_state   <= S_HALT;
                        r_mem_rd  <= 1'b0;
                        r_mem_wr  <= 1'b0;
                        r_trap    <= 1'b1;
                        r_halted  <= 1'b1;
                        r_aluop   <= '0;
                        r_alu_src <= 1'b0;
                        r_branch  <= 1'b0;
                        r_mux_inp <= 1'b0;
                        r_fn3     <= '0;
                        r_fn7_5   <= 1'b0;
                        r_imm11_5 <= '0;
                    end else begin
                        r_mem_cnt <= r_mem_cnt + CNT_W'(1);
                    end
                end
                S_WB: begin
                    r_state     <= S_FETCH;
                    r_instr_req <= 1'b1;
                    r_instret   <= r_instret + XLEN'(1);
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state     <= S_FETCH;
                    r_instr_req <= 1'b1;
                end
            endcase
        end
    end

    assign bus.aluop     = r_aluop;
    assign bus.alu_src   = r_alu_src;
    assign bus.branch    = r_branch;
    assign bus.mux_inp   = r_mux_inp;
    assign bus.fn3       = r_fn3;
    assign bus.fn7_5     = r_fn7_5;
    assign bus.imm11_5   = r_imm11_5;
    assign bus.instr_req = r_instr_req;
    assign bus.ir_we     = r_ir_we;
    assign bus.mem_rd    = r_mem_rd;
    assign bus.mem_wr    = r_mem_wr;
    assign bus.reg_we    = r_reg_we;
    assign bus.pc_we     = r_pc_we;
    assign bus.pc_src    = r_pc_src;
    assign bus.trap      = r_trap;
    assign bus.halted    = r_halted;
    assign bus.instret   = r_instret;

endmodule

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: maximum cycles spent in MEM waiting for mem_ready (1..255).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1: reset; synchronous and active-high.
REQ-004 SHALL have port instr, input, 32: instruction word from instruction memory.
REQ-005 SHALL have port instr_valid, input, 1: instr is valid this cycle.
REQ-006 SHALL have port mem_ready, input, 1: data memory has completed the access.
REQ-007 SHALL have port and_out_ex, input, 1: branch-taken flag from the execution stage.
REQ-008 SHALL have the following execution-stage control outputs:
- aluop, output, 3;
- alu_src, output, 1;
- branch, output, 1;
- mux_inp, output, 1;
- fn3, output, 3;
- fn7_5, output, 1;
- imm11_5, output, 7.
REQ-009 SHALL have the following sequencing outputs, each 1 bit:
- instr_req: instruction fetch request;
- ir_we: latch the instruction register;
- mem_rd: data memory read;
- mem_wr: data memory write;
- reg_we: register-file write;
- pc_we: program-counter write;
- pc_src: 0 selects PC+4, 1 selects pc_ex_out;
- trap: illegal opcode or memory timeout;
- halted: controller is in HALT.
REQ-010 SHALL have port instret, output, 32: count of retired instructions.

Function
REQ-011 SHALL implement a Moore FSM with states FETCH, DECODE, EXEC, MEM, WB and HALT; reset state is FETCH.
REQ-012 SHALL, in FETCH, assert instr_req; on instr_valid it SHALL pulse ir_we and move to DECODE; otherwise it SHALL stay in FETCH.
REQ-013 SHALL, in DECODE, register the decoded controls:
- fn3 = instr[14:12];
- fn7_5 = instr[30];
- imm11_5 = instr[31:25].
REQ-014 SHALL map opcode to aluop / alu_src / mux_inp as follows:
- R (0110011): 000 / 0 / 0;
- I-ALU (0010011): 001 / 1 / 0;
- load (0000011): 010 / 1 / 0;
- store (0100011): 011 / 1 / 0;
- branch (1100011): 100 / 0 / 0, with branch=1;
- JAL (1101111): 101 / 1 / 0;
- JALR (1100111): 001 / 1 / 1;
- LUI (0110111): 110 / 1 / 0;
- AUIPC (0010111): 001 / 1 / 0.
REQ-015 SHALL treat any other opcode as illegal: trap pulses for 1 cycle and the FSM goes DECODE->HALT.
REQ-016 SHALL hold the registered controls stable from EXEC until the next DECODE.
REQ-017 SHALL, in EXEC for a branch, pulse pc_we with pc_src=and_out_ex, increment instret and return to FETCH.
REQ-018 SHALL, in EXEC, go to MEM for load/store and to WB for all other opcodes.
REQ-019 SHALL, in MEM, hold mem_rd (load) or mem_wr (store) high until mem_ready.
REQ-020 SHALL, on mem_ready in MEM:
- for a load, drop the request and go to WB;
- for a store, pulse pc_we with pc_src=0, increment instret and go to FETCH.
REQ-021 SHALL count MEM cycles in an 8-bit counter cleared on MEM entry; if the count reaches MEM_TIMEOUT without mem_ready, it SHALL pulse trap, drop mem_rd/mem_wr and enter HALT.
REQ-022 SHALL let mem_ready win over timeout when both occur in the same cycle.
REQ-023 SHALL, in WB, pulse reg_we and pc_we for 1 cycle, with pc_src=1 for JAL/JALR and 0 otherwise; it SHALL increment instret and go to FETCH.
REQ-024 SHALL wrap instret modulo 2^32.
REQ-025 SHALL, in HALT, assert halted and hold every other control output at 0 until rst.
REQ-026 SHALL ignore instr_valid and mem_ready outside FETCH and MEM respectively.
REQ-027 SHALL give latency R/I/U/J = 4 cycles, branch = 3, store = 4+wait, load = 5+wait, where wait is the number of cycles mem_ready is low in MEM.

Reset
REQ-028 SHALL, on rst, set state=FETCH, instret=0, MEM counter=0, all registered controls=0 and all pulse outputs=0, effective at the next edge.
REQ-029 SHALL, on rst mid-operation (including MEM with mem_rd/mem_wr high, or HALT), abort the instruction with no reg_we/pc_we and deassert mem_rd/mem_wr at that edge.

Structure
REQ-030 SHALL take the state enum, the opcode constants and the aluop encodings from shared package exec_ctrl_pkg.
REQ-031 SHALL place the opcode-to-control mapping in combinational sub-module exec_ctrl_decode, with the FSM, counters and registers in exec_ctrl.

Verification
REQ-032 SHALL cover ADD: instr=0x002081B3 -> aluop=000, alu_src=0, fn3=000; reg_we pulses in the 4th cycle after instr_valid; instret=1.
REQ-033 SHALL cover LW: instr=0x0100A283 with mem_ready held low 3 cycles -> mem_rd high 4 cycles, aluop=010, fn3=010, then reg_we; total 8 cycles.
REQ-034 SHALL cover BEQ: instr=0x00208463 with and_out_ex=1 -> pc_we with pc_src=1 in EXEC; with and_out_ex=0 -> pc_src=0; no reg_we in either case.
REQ-035 SHALL cover illegal instruction: instr=0xFFFFFFFF -> trap pulses 1 cycle, halted=1, instr_req=0 until rst.
REQ-036 SHALL cover timeout: SW with mem_ready=0 and MEM_TIMEOUT=4 -> mem_wr high 4 cycles, then trap and HALT; mem_ready arriving on cycle 4 instead -> normal retire.
REQ-037 SHALL cover reset mid-MEM: rst asserted during an LW wait -> mem_rd=0 next cycle, instret unchanged at 0, state FETCH.
